// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample, mid-bit and bit ticks from a runtime int+frac divisor.
// Define BAUD_PRESET_EN to add the sel/preset_load preset table.
module baud_gen_frac #(
    parameter int unsigned     DIV_W    = 16,
    parameter int unsigned     FRAC_W   = 4,
    parameter int unsigned     OVS      = 16,
    parameter int unsigned     DEF_INT  = 54,
    parameter int unsigned     DEF_FRAC = 4,
    parameter longint unsigned CLK_HZ   = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
`ifdef BAUD_PRESET_EN
    input  logic [1:0]        sel,
    input  logic              preset_load,
`endif
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              div_pend,
    output logic              cfg_err
);

    localparam int unsigned      OS_W    = $clog2(OVS);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVS - 1);
    localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OVS / 2 - 1);
    localparam logic [OS_W-1:0]  OS_ONE  = OS_W'(1);
    localparam logic [DIV_W-1:0] INT_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] INT_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] INT_MAX = {DIV_W{1'b1}};

    if (OVS < 4 || (OVS % 2) != 0 || CLK_HZ == 0) begin : g_param_err
        $error("baud_gen_frac: OVS must be even and >= 4, CLK_HZ nonzero");
    end

    logic [DIV_W-1:0]  act_int_q, act_int_d, sh_int_q, sh_int_d, cnt_q, cnt_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d, sh_frac_q, sh_frac_d, acc_q, acc_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic              pend_q, pend_d, err_q, err_d;
    logic              os_q, os_d, mid_q, mid_d, bit_q, bit_d;

    logic              ld;
    logic [DIV_W-1:0]  ld_int;
    logic [FRAC_W-1:0] ld_frac;
    logic [FRAC_W:0]   acc_sum;
    logic              cnt_zero, bit_end, apply;

`ifdef BAUD_PRESET_EN
    // int = floor(CLK_HZ/(OVS*baud)); frac = remainder rounded to 1/2^FRAC_W.
    function automatic logic [DIV_W+FRAC_W-1:0] preset_div(input longint unsigned baud);
        longint unsigned den, q, r, f;
        den = 64'(OVS) * baud;
        q   = CLK_HZ / den;
        r   = CLK_HZ % den;
        f   = ((r << (FRAC_W + 1)) + den) / (den << 1);
        if (f >= (64'd1 << FRAC_W)) begin
            q = q + 1;
            f = 0;
        end
        return {q[DIV_W-1:0], f[FRAC_W-1:0]};
    endfunction

    localparam logic [DIV_W+FRAC_W-1:0] PRE_9600   = preset_div(64'd9600);
    localparam logic [DIV_W+FRAC_W-1:0] PRE_19200  = preset_div(64'd19200);
    localparam logic [DIV_W+FRAC_W-1:0] PRE_57600  = preset_div(64'd57600);
    localparam logic [DIV_W+FRAC_W-1:0] PRE_115200 = preset_div(64'd115200);

    logic [DIV_W+FRAC_W-1:0] pre_div;

    always_comb begin
        case (sel)
            2'b00:   pre_div = PRE_9600;
            2'b01:   pre_div = PRE_19200;
            2'b10:   pre_div = PRE_57600;
            default: pre_div = PRE_115200;
        endcase
    end
`endif

    always_comb begin
        ld      = div_load;
        ld_int  = div_int;
        ld_frac = div_frac;
`ifdef BAUD_PRESET_EN
        if (!div_load && preset_load) begin
            ld                = 1'b1;
            {ld_int, ld_frac} = pre_div;
        end
`endif
    end

    always_comb begin
        acc_sum  = {1'b0, acc_q} + {1'b0, act_frac_q};
        cnt_zero = (cnt_q == '0);
        bit_end  = en && cnt_zero && (os_cnt_q == OS_LAST);
        apply    = pend_q && (!en || bit_end);

        act_int_d  = apply ? sh_int_q : act_int_q;
        act_frac_d = apply ? sh_frac_q : act_frac_q;

        cnt_d    = cnt_q;
        acc_d    = acc_q;
        os_cnt_d = os_cnt_q;
        os_d     = 1'b0;
        mid_d    = 1'b0;
        bit_d    = 1'b0;

        if (!en) begin
            cnt_d    = act_int_d - INT_ONE;
            acc_d    = '0;
            os_cnt_d = '0;
        end else if (cnt_zero) begin
            os_d     = 1'b1;
            mid_d    = (os_cnt_q == OS_MID);
            bit_d    = bit_end;
            os_cnt_d = bit_end ? '0 : os_cnt_q + OS_ONE;
            if (apply) begin
                acc_d = '0;
                cnt_d = sh_int_q - INT_ONE;
            end else begin
                acc_d = acc_sum[FRAC_W-1:0];
                // A carry stretches the period by one clock unless that would overflow DIV_W.
                cnt_d = (acc_sum[FRAC_W] && act_int_q != INT_MAX) ? act_int_q
                                                                  : act_int_q - INT_ONE;
            end
        end else begin
            cnt_d = cnt_q - INT_ONE;
        end

        // A load on the apply edge lands in the shadow and stays pending.
        sh_int_d  = sh_int_q;
        sh_frac_d = sh_frac_q;
        pend_d    = pend_q && !apply;
        err_d     = err_q;
        if (ld) begin
            sh_int_d  = (ld_int < INT_MIN) ? INT_MIN : ld_int;
            sh_frac_d = ld_frac;
            pend_d    = 1'b1;
            err_d     = (ld_int < INT_MIN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_int_q  <= DIV_W'(DEF_INT);
            act_frac_q <= FRAC_W'(DEF_FRAC);
            sh_int_q   <= DIV_W'(DEF_INT);
            sh_frac_q  <= FRAC_W'(DEF_FRAC);
            cnt_q      <= DIV_W'(DEF_INT - 1);
            acc_q      <= '0;
            os_cnt_q   <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            os_q       <= 1'b0;
            mid_q      <= 1'b0;
            bit_q      <= 1'b0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            os_cnt_q   <= os_cnt_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            os_q       <= os_d;
            mid_q      <= mid_d;
            bit_q      <= bit_d;
        end
    end

    assign os_tick  = os_q;
    assign mid_tick = mid_q;
    assign bit_tick = bit_q;
    assign div_pend = pend_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: divisor table sweep plus hand sequences for
// bit-boundary apply, coincident load and asynchronous reset.
module tb_baud_gen_frac;

    localparam int OVS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        div_load = 1'b0;
    logic        os_tick, mid_tick, bit_tick, div_pend, cfg_err;
`ifdef BAUD_PRESET_EN
    logic [1:0]  sel = 2'b00;
    logic        preset_load = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    baud_gen_frac dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
`ifdef BAUD_PRESET_EN
        .sel         (sel),
        .preset_load (preset_load),
`endif
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .bit_tick (bit_tick),
        .div_pend (div_pend),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int di;
        int df;
        int err;
        int first;
        int minv;
        int maxv;
        int lng;
        int bper;
        int nbits;
    } vec_t;

    vec_t vecs[7];

    int st_first, st_min, st_max, st_long, st_bmin, st_bmax, st_bits, st_bad;
    int prev_ts, iv_bad;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int di, input int df);
        div_int  = 16'(di);
        div_frac = 4'(df);
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    task automatic wait_os(output int ts);
        int n = 0;
        ts = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!os_tick && n < 2000);
        if (os_tick) ts = cyc;
    endtask

    task automatic ticks(input int n, input int iv);
        int ts;
        for (int i = 0; i < n; i++) begin
            wait_os(ts);
            if (ts - prev_ts != iv) iv_bad++;
            prev_ts = ts;
        end
    endtask

    // Runs from the first enabled edge; tick positions are checked against the os index.
    task automatic measure(input int nbits, input int ival);
        int   t, last_os, last_bit, idx, budget, iv;
        logic prev_os;
        budget   = (nbits + 1) * OVS * (ival + 1) + 50;
        st_first = 0;
        st_min   = 1 << 30;
        st_max   = 0;
        st_long  = 0;
        st_bmin  = 1 << 30;
        st_bmax  = 0;
        st_bits  = 0;
        st_bad   = 0;
        t        = 0;
        last_os  = 0;
        last_bit = 0;
        idx      = 0;
        prev_os  = 1'b0;
        while (st_bits < nbits && t < budget) begin
            @(negedge clk);
            t++;
            if (os_tick) begin
                idx++;
                if (idx == 1) st_first = t;
                else begin
                    iv = t - last_os;
                    if (iv < st_min) st_min = iv;
                    if (iv > st_max) st_max = iv;
                    if (idx >= OVS + 1 && idx <= 2 * OVS && iv == ival + 1) st_long++;
                end
                last_os = t;
            end
            if ((os_tick && (idx % OVS) == OVS / 2) != mid_tick) st_bad++;
            if ((os_tick && (idx % OVS) == 0) != bit_tick) st_bad++;
            if (os_tick && prev_os) st_bad++;
            prev_os = os_tick;
            if (bit_tick) begin
                st_bits++;
                if (st_bits > 1) begin
                    if (t - last_bit < st_bmin) st_bmin = t - last_bit;
                    if (t - last_bit > st_bmax) st_bmax = t - last_bit;
                end
                last_bit = t;
            end
        end
    endtask

    initial begin
        int ts, bit_ts;

        //            di  df err first min max lng  bper nbits
        vecs[0] = '{10,  0, 0, 10,  10, 10, 0,  160, 3};
        vecs[1] = '{54,  4, 0, 54,  54, 55, 4,  868, 11};
        vecs[2] = '{1,   0, 1, 2,   2,  2,  0,  32,  3};
        vecs[3] = '{8,   0, 0, 8,   8,  8,  0,  128, 3};
        vecs[4] = '{5,   8, 0, 5,   5,  6,  8,  88,  3};
        vecs[5] = '{0,  15, 1, 2,   2,  3,  15, 47,  3};
        vecs[6] = '{3,   1, 0, 3,   3,  4,  1,  49,  3};

        #1 rst = 1'b1;
        #1;
        check("reset os_tick", os_tick, 0);
        check("reset mid_tick", mid_tick, 0);
        check("reset bit_tick", bit_tick, 0);
        check("reset div_pend", div_pend, 0);
        check("reset cfg_err", cfg_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            load(vecs[i].di, vecs[i].df);
            check($sformatf("v%0d pend set", i), div_pend, 1);
            check($sformatf("v%0d cfg_err", i), cfg_err, vecs[i].err);
            @(negedge clk);
            check($sformatf("v%0d pend idle apply", i), div_pend, 0);
            en = 1'b1;
            measure(vecs[i].nbits, vecs[i].first);
            en = 1'b0;
            check($sformatf("v%0d bits seen", i), st_bits, vecs[i].nbits);
            check($sformatf("v%0d first os", i), st_first, vecs[i].first);
            check($sformatf("v%0d min period", i), st_min, vecs[i].minv);
            check($sformatf("v%0d max period", i), st_max, vecs[i].maxv);
            check($sformatf("v%0d long periods", i), st_long, vecs[i].lng);
            check($sformatf("v%0d bit period min", i), st_bmin, vecs[i].bper);
            check($sformatf("v%0d bit period max", i), st_bmax, vecs[i].bper);
            check($sformatf("v%0d tick placement", i), st_bad, 0);
        end

        // Mid-bit load applies at the bit boundary; a coincident load waits one more bit.
        iv_bad = 0;
        load(10, 0);
        @(negedge clk);
        en      = 1'b1;
        prev_ts = cyc;
        ticks(5, 10);
        load(20, 0);
        check("seqA pend set", div_pend, 1);
        ticks(11, 10);
        check("seqA bit edge", bit_tick, 1);
        @(negedge clk);
        check("seqA pend clr", div_pend, 0);
        ticks(1, 20);
        load(25, 0);
        ticks(14, 20);
        repeat (19) @(negedge clk);
        div_int  = 16'd30;
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        check("seqA coincident bit", bit_tick, 1);
        check("seqA pend held", div_pend, 1);
        if (cyc - prev_ts != 20) iv_bad++;
        prev_ts = cyc;
        bit_ts  = cyc;
        ticks(16, 25);
        check("seqA bit at 25", bit_tick, 1);
        check("seqA bit period 25", prev_ts - bit_ts, 400);
        @(negedge clk);
        check("seqA pend clr2", div_pend, 0);
        ticks(1, 30);
        check("seqA intervals", iv_bad, 0);

        // Asynchronous reset between edges while outputs are active.
        load(1, 0);
        check("seqB pend pre", div_pend, 1);
        check("seqB err pre", cfg_err, 1);
        wait_os(ts);
        check("seqB interval", ts - prev_ts, 30);
        #2 rst = 1'b1;
        #1;
        check("seqB os_tick", os_tick, 0);
        check("seqB div_pend", div_pend, 0);
        check("seqB cfg_err", cfg_err, 0);
        check("seqB mid/bit", {mid_tick, bit_tick}, 0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        measure(3, 54);
        en = 1'b0;
        check("seqB default first", st_first, 54);
        check("seqB default bit period", st_bmin, 868);
        check("seqB default long", st_long, 4);
        check("seqB tick placement", st_bad, 0);

`ifdef BAUD_PRESET_EN
        @(negedge clk);
        sel         = 2'b11;
        preset_load = 1'b1;
        @(negedge clk);
        preset_load = 1'b0;
        check("preset 115200 pend", div_pend, 1);
        @(negedge clk);
        en = 1'b1;
        measure(3, 54);
        en = 1'b0;
        check("preset 115200 first", st_first, 54);
        check("preset 115200 bit period", st_bmax, 868);
        sel         = 2'b00;
        preset_load = 1'b1;
        @(negedge clk);
        preset_load = 1'b0;
        @(negedge clk);
        en = 1'b1;
        measure(3, 651);
        en = 1'b0;
        check("preset 9600 first", st_first, 651);
        check("preset 9600 long", st_long, 1);
        check("preset 9600 bit period", st_bmin, 10417);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
